char_line_renderer: RTL

- Parametrised, standalone successor to the inline character renderer in the VGA text top level.
- On a start pulse, renders one display pixel row of NUM_COLS character cells into the pixel buffer.
- Per cell: fetches the attribute/code word from the character row buffer, the glyph row from font memory, and bg/fg colours from the palette, then writes GLYPH_W pixels.
- Unlike the inline version, it prefetches before writing (no junk pixels), supports a base address for double buffering, and has an optional blink attribute.

---
 rtl/char_line_renderer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/char_line_renderer.sv
// Renders one pixel row of NUM_COLS character cells into the pixel buffer. The next cell is prefetched while the current one renders.
// Output timing: first pixbuf write comes 5 cycles after start. There is no backpressure; start is only accepted while idle.
module char_line_renderer #(
  parameter int NUM_COLS = 100,
  parameter int GLYPH_W  = 8,
  parameter int ROW_BITS = 4,
  parameter int CHROW_AW = 8,
  parameter int PIX_AW   = 10,
  parameter bit BLINK_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               pixel_row,
  input  logic [PIX_AW-1:0]         pix_base,
  input  logic                      blink_phase,
  output logic                      busy,
  output logic                      done,
  output logic                      chrowbuf_rd,
  output logic [CHROW_AW-1:0]       chrowbuf_rd_addr,
  input  logic [15:0]               chrowbuf_rd_data,
  output logic                      fontmem_rd,
  output logic [8+ROW_BITS-1:0]     fontmem_rd_addr,
  input  logic [GLYPH_W-1:0]        fontmem_rd_data,
  output logic                      palette_rd,
  output logic [7:0]                palette_rd_addr,
  input  logic [15:0]               palette_rd_data,
  output logic                      pixbuf_wr,
  output logic [PIX_AW-1:0]         pixbuf_wr_addr,
  output logic [15:0]               pixbuf_wr_data
);

  localparam int TW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRE    = 2'd1;
  localparam logic [1:0] S_RENDER = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          r_state;
  logic [ROW_BITS-1:0] r_row;
  logic                r_phase;
  logic [PIX_AW-1:0]   r_waddr;
  logic [TW-1:0]       r_tick;
  logic [CW-1:0]       r_cell;

  logic                r_fact;
  logic [1:0]          r_fph;
  logic [CHROW_AW-1:0] r_fcell;
  logic [15:0]         r_nxt_word;
  logic [GLYPH_W-1:0]  r_nxt_glyph;
  logic [15:0]         r_nxt_bg;
  logic [15:0]         r_nxt_fg;

  logic [GLYPH_W-1:0]  r_cur_glyph;
  logic [15:0]         r_cur_bg;
  logic [15:0]         r_cur_fg;

  logic [3:0]          w_bg_idx_in;
  logic [15:0]         w_fg_src;
  logic [15:0]         w_fg_eff;
  logic                w_last_tick;
  logic                w_last_cell;
  logic                w_load;
  logic [CW-1:0]       w_load_cell;
  logic                w_more;
  logic                w_unused_bits;

  assign w_unused_bits = ^pixel_row[15:ROW_BITS];

  assign w_bg_idx_in = BLINK_EN ? {1'b0, chrowbuf_rd_data[14:12]} : chrowbuf_rd_data[15:12];

  // The fg colour may be arriving on the same edge as the load (prefetch end, or GLYPH_W == 4).
  assign w_fg_src = (r_fact && r_fph == 2'd3) ? palette_rd_data : r_nxt_fg;
  assign w_fg_eff = (BLINK_EN && r_nxt_word[15] && r_phase) ? r_nxt_bg : w_fg_src;

  assign w_last_tick = (r_tick == TW'(GLYPH_W - 1));
  assign w_last_cell = (r_cell == CW'(NUM_COLS - 1));
  assign w_load      = (r_state == S_PRE && r_fph == 2'd3) ||
                       (r_state == S_RENDER && w_last_tick && !w_last_cell);
  assign w_load_cell = (r_state == S_PRE) ? '0 : CW'(r_cell + 1'b1);
  assign w_more      = (int'(w_load_cell) < NUM_COLS - 1);

  assign busy = (r_state == S_PRE) || (r_state == S_RENDER);
  assign done = (r_state == S_DONE);

  always_comb begin
    chrowbuf_rd      = 1'b1;
    chrowbuf_rd_addr = '0;
    fontmem_rd       = 1'b1;
    fontmem_rd_addr  = '0;
    palette_rd       = 1'b1;
    palette_rd_addr  = '0;
    pixbuf_wr        = 1'b1;
    pixbuf_wr_addr   = '0;
    pixbuf_wr_data   = '0;
    if (r_fact) begin
      case (r_fph)
        2'd0: begin
          chrowbuf_rd      = 1'b0;
          chrowbuf_rd_addr = r_fcell;
        end
        2'd1: begin
          palette_rd      = 1'b0;
          palette_rd_addr = {4'd0, w_bg_idx_in};
          fontmem_rd      = 1'b0;
          fontmem_rd_addr = {chrowbuf_rd_data[7:0], r_row};
        end
        2'd2: begin
          palette_rd      = 1'b0;
          palette_rd_addr = {4'd0, r_nxt_word[11:8]};
        end
        default: ;
      endcase
    end
    if (r_state == S_RENDER) begin
      pixbuf_wr      = 1'b0;
      pixbuf_wr_addr = r_waddr;
      pixbuf_wr_data = r_cur_glyph[GLYPH_W-1] ? r_cur_fg : r_cur_bg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_phase     <= 1'b0;
      r_waddr     <= '0;
      r_tick      <= '0;
      r_cell      <= '0;
      r_fact      <= 1'b0;
      r_fph       <= 2'd0;
      r_fcell     <= '0;
      r_nxt_word  <= '0;
      r_nxt_glyph <= '0;
      r_nxt_bg    <= '0;
      r_nxt_fg    <= '0;
      r_cur_glyph <= '0;
      r_cur_bg    <= '0;
      r_cur_fg    <= '0;
    end else begin
      if (r_fact) begin
        case (r_fph)
          2'd1: r_nxt_word <= chrowbuf_rd_data;
          2'd2: begin
            r_nxt_glyph <= fontmem_rd_data;
            r_nxt_bg    <= palette_rd_data;
          end
          2'd3: r_nxt_fg <= palette_rd_data;
          default: ;
        endcase
        r_fph <= r_fph + 2'd1;
        if (r_fph == 2'd3)
          r_fact <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_PRE;
            r_row   <= pixel_row[ROW_BITS-1:0];
            r_phase <= blink_phase;
            r_waddr <= pix_base;
            r_tick  <= '0;
            r_cell  <= '0;
            r_fact  <= 1'b1;
            r_fph   <= 2'd0;
            r_fcell <= '0;
          end
        end
        S_PRE: begin
          if (r_fph == 2'd3)
            r_state <= S_RENDER;
        end
        S_RENDER: begin
          r_waddr     <= r_waddr + 1'b1;
          r_cur_glyph <= r_cur_glyph << 1;
          if (w_last_tick) begin
            r_tick <= '0;
            if (w_last_cell)
              r_state <= S_DONE;
            else
              r_cell <= r_cell + 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Entering tick 0 of a cell: promote prefetched data and kick off the following cell's fetch.
      if (w_load) begin
        r_cur_glyph <= r_nxt_glyph;
        r_cur_bg    <= r_nxt_bg;
        r_cur_fg    <= w_fg_eff;
        if (w_more) begin
          r_fact  <= 1'b1;
          r_fph   <= 2'd0;
          r_fcell <= CHROW_AW'(w_load_cell) + CHROW_AW'(1);
        end
      end
    end
  end

endmodule
